sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_port_arbiter_pkg.sv | 27 ++
 rtl/sdram_port_arbiter_if.sv | 66 ++++++
 rtl/sdram_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_port_arbiter_pkg.sv
// Shared SDRAM parameters, arbiter state encoding and the round-robin picker
// for the two-port SDRAM front-end arbiter.
package sdram_port_arbiter_pkg;

    localparam int unsigned SDR_ASIZE  = 23;
    localparam int unsigned SDR_DSIZE  = 16;
    localparam int unsigned SDR_LEN_W  = 8;
    localparam int unsigned ARB_TMO    = 1023;
    localparam int unsigned WDOG_W     = 10;
    localparam int unsigned GAP_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } arb_state_e;

    // Returns the winning port index; on a tie the pointer decides.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic ptr);
        if (req0 && req1) begin
            return ptr;
        end
        return req1;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Host-port and controller-side bundle of the two-port SDRAM arbiter.
interface sdram_port_arbiter_if #(
    parameter int unsigned ASIZE = 23,
    parameter int unsigned DSIZE = 16
);
    localparam int unsigned DMW = DSIZE / 8;

    logic             p0_req;
    logic             p0_wrn;
    logic [ASIZE-1:0] p0_addr;
    logic [7:0]       p0_len;
    logic [DSIZE-1:0] p0_din;
    logic [DMW-1:0]   p0_dm;
    logic             p0_gnt;
    logic             p0_done;
    logic             p0_err;
    logic             p0_in_req;
    logic             p0_out_valid;
    logic [DSIZE-1:0] p0_dout;

    logic             p1_req;
    logic             p1_wrn;
    logic [ASIZE-1:0] p1_addr;
    logic [7:0]       p1_len;
    logic [DSIZE-1:0] p1_din;
    logic [DMW-1:0]   p1_dm;
    logic             p1_gnt;
    logic             p1_done;
    logic             p1_err;
    logic             p1_in_req;
    logic             p1_out_valid;
    logic [DSIZE-1:0] p1_dout;

    logic [ASIZE-1:0] c_addr;
    logic [7:0]       c_length;
    logic             c_wr;
    logic             c_rd;
    logic [DSIZE-1:0] c_datain;
    logic [DMW-1:0]   c_dm;
    logic [DSIZE-1:0] c_dataout;
    logic             c_in_req;
    logic             c_out_valid;
    logic             c_done;
    logic             c_act;

    // Arbiter side
    modport slave (
        input  p0_req, p0_wrn, p0_addr, p0_len, p0_din, p0_dm,
        output p0_gnt, p0_done, p0_err, p0_in_req, p0_out_valid, p0_dout,
        input  p1_req, p1_wrn, p1_addr, p1_len, p1_din, p1_dm,
        output p1_gnt, p1_done, p1_err, p1_in_req, p1_out_valid, p1_dout,
        output c_addr, c_length, c_wr, c_rd, c_datain, c_dm,
        input  c_dataout, c_in_req, c_out_valid, c_done, c_act
    );

    // Hosts plus SDRAM controller side
    modport master (
        output p0_req, p0_wrn, p0_addr, p0_len, p0_din, p0_dm,
        input  p0_gnt, p0_done, p0_err, p0_in_req, p0_out_valid, p0_dout,
        output p1_req, p1_wrn, p1_addr, p1_len, p1_din, p1_dm,
        input  p1_gnt, p1_done, p1_err, p1_in_req, p1_out_valid, p1_dout,
        input  c_addr, c_length, c_wr, c_rd, c_datain, c_dm,
        output c_dataout, c_in_req, c_out_valid, c_done, c_act
    );

endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter in front of an SDRAM controller, with a
// per-burst watchdog and an enforced idle gap between bursts.
module sdram_port_arbiter
    import sdram_port_arbiter_pkg::*;
#(
    parameter int unsigned ASIZE = SDR_ASIZE,
    parameter int unsigned DSIZE = SDR_DSIZE,
    parameter int unsigned TMO   = ARB_TMO
) (
    input logic                 CLK,
    input logic                 RESET_N,
    sdram_port_arbiter_if.slave bus
);

    localparam int unsigned DMW = DSIZE / 8;

    arb_state_e           state_q, state_d;
    logic                 ptr_q, ptr_d;
    logic                 sel_q, sel_d;
    logic                 wrn_q, wrn_d;
    logic [WDOG_W-1:0]    wdog_q, wdog_d;
    logic                 gap_q, gap_d;
    logic                 gnt0_q, gnt0_d;
    logic                 gnt1_q, gnt1_d;
    logic                 done0_q, done0_d;
    logic                 done1_q, done1_d;
    logic                 err0_q, err0_d;
    logic                 err1_q, err1_d;
    logic                 c_wr_q, c_wr_d;
    logic                 c_rd_q, c_rd_d;
    logic [ASIZE-1:0]     c_addr_q, c_addr_d;
    logic [SDR_LEN_W-1:0] c_len_q, c_len_d;
    logic                 pick;
    logic                 finish;
    logic                 ctrl_act_unused;

    // Controller activity flag carries no arbitration meaning here.
    assign ctrl_act_unused = bus.c_act;

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        wrn_d    = wrn_q;
        wdog_d   = wdog_q;
        gap_d    = gap_q;
        gnt0_d   = gnt0_q;
        gnt1_d   = gnt1_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        c_wr_d   = c_wr_q;
        c_rd_d   = c_rd_q;
        c_addr_d = c_addr_q;
        c_len_d  = c_len_q;
        pick     = 1'b0;
        finish   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.p0_req || bus.p1_req) begin
                    pick     = rr_pick(bus.p0_req, bus.p1_req, ptr_q);
                    sel_d    = pick;
                    ptr_d    = ~pick;
                    gnt0_d   = ~pick;
                    gnt1_d   = pick;
                    c_addr_d = pick ? bus.p1_addr : bus.p0_addr;
                    c_len_d  = pick ? bus.p1_len  : bus.p0_len;
                    wrn_d    = pick ? bus.p1_wrn  : bus.p0_wrn;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // Zero-length bursts complete without touching the controller.
                if (c_len_q == SDR_LEN_W'(0)) begin
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    done0_d = ~sel_q;
                    done1_d = sel_q;
                    state_d = IDLE;
                end else begin
                    c_wr_d  = wrn_q;
                    c_rd_d  = ~wrn_q;
                    wdog_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                finish = bus.c_done || (wdog_q == WDOG_W'(TMO));
                if (finish) begin
                    c_wr_d  = 1'b0;
                    c_rd_d  = 1'b0;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    done0_d = bus.c_done & ~sel_q;
                    done1_d = bus.c_done & sel_q;
                    err0_d  = ~bus.c_done & ~sel_q;
                    err1_d  = ~bus.c_done & sel_q;
                    gap_d   = 1'b0;
                    state_d = GAP;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            GAP: begin
                if (gap_q == 1'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            sel_q    <= 1'b0;
            wrn_q    <= 1'b0;
            wdog_q   <= '0;
            gap_q    <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            c_wr_q   <= 1'b0;
            c_rd_q   <= 1'b0;
            c_addr_q <= '0;
            c_len_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            wrn_q    <= wrn_d;
            wdog_q   <= wdog_d;
            gap_q    <= gap_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            c_wr_q   <= c_wr_d;
            c_rd_q   <= c_rd_d;
            c_addr_q <= c_addr_d;
            c_len_q  <= c_len_d;
        end
    end

    assign bus.p0_gnt   = gnt0_q;
    assign bus.p1_gnt   = gnt1_q;
    assign bus.p0_done  = done0_q;
    assign bus.p1_done  = done1_q;
    assign bus.p0_err   = err0_q;
    assign bus.p1_err   = err1_q;
    assign bus.c_wr     = c_wr_q;
    assign bus.c_rd     = c_rd_q;
    assign bus.c_addr   = c_addr_q;
    assign bus.c_length = c_len_q;

    // Data path steered by the registered grant; idle drives zero data, fully masked.
    assign bus.c_datain = gnt1_q ? bus.p1_din : (gnt0_q ? bus.p0_din : DSIZE'(0));
    assign bus.c_dm     = gnt1_q ? bus.p1_dm  : (gnt0_q ? bus.p0_dm  : {DMW{1'b1}});

    assign bus.p0_in_req    = bus.c_in_req & gnt0_q;
    assign bus.p1_in_req    = bus.c_in_req & gnt1_q;
    assign bus.p0_out_valid = bus.c_out_valid & gnt0_q;
    assign bus.p1_out_valid = bus.c_out_valid & gnt1_q;
    assign bus.p0_dout      = bus.c_dataout;
    assign bus.p1_dout      = bus.c_dataout;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios followed by
// randomized request mixes checked against a transaction-level model.
module tb_sdram_port_arbiter;
    import sdram_port_arbiter_pkg::*;

    localparam int unsigned AW  = SDR_ASIZE;
    localparam int unsigned DW  = SDR_DSIZE;
    localparam int unsigned MW  = DW / 8;
    localparam int unsigned TMO = ARB_TMO;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdram_port_arbiter_if #(.ASIZE(AW), .DSIZE(DW)) bus ();

    sdram_port_arbiter #(.ASIZE(AW), .DSIZE(DW), .TMO(TMO)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: requested transactions per port and the expected tie-break owner.
    logic          req  [2];
    logic          wrn  [2];
    logic [AW-1:0] addr [2];
    logic [7:0]    len  [2];
    logic [DW-1:0] din  [2];
    logic [MW-1:0] dm   [2];
    int            exp_ptr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ports();
        bus.p0_req = req[0]; bus.p0_wrn = wrn[0]; bus.p0_addr = addr[0];
        bus.p0_len = len[0]; bus.p0_din = din[0]; bus.p0_dm   = dm[0];
        bus.p1_req = req[1]; bus.p1_wrn = wrn[1]; bus.p1_addr = addr[1];
        bus.p1_len = len[1]; bus.p1_din = din[1]; bus.p1_dm   = dm[1];
    endtask

    task automatic set_port(input int p, input logic r, input logic w, input logic [AW-1:0] a,
                            input logic [7:0] l);
        req[p] = r; wrn[p] = w; addr[p] = a; len[p] = l;
        din[p] = DW'($urandom); dm[p] = MW'($urandom);
    endtask

    function automatic logic gnt_of(input int p);  return (p == 1) ? bus.p1_gnt  : bus.p0_gnt;  endfunction
    function automatic logic done_of(input int p); return (p == 1) ? bus.p1_done : bus.p0_done; endfunction
    function automatic logic err_of(input int p);  return (p == 1) ? bus.p1_err  : bus.p0_err;  endfunction
    function automatic logic inreq_of(input int p); return (p == 1) ? bus.p1_in_req : bus.p0_in_req; endfunction
    function automatic logic ov_of(input int p);   return (p == 1) ? bus.p1_out_valid : bus.p0_out_valid; endfunction
    function automatic logic [DW-1:0] dout_of(input int p); return (p == 1) ? bus.p1_dout : bus.p0_dout; endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},  {bus.p0_gnt, bus.p1_gnt}, 0);
        chk({tag, "_done"}, {bus.p0_done, bus.p1_done}, 0);
        chk({tag, "_err"},  {bus.p0_err, bus.p1_err}, 0);
        chk({tag, "_cmd"},  {bus.c_wr, bus.c_rd}, 0);
        chk({tag, "_addr"}, bus.c_addr, 0);
        chk({tag, "_len"},  bus.c_length, 0);
        chk({tag, "_din"},  bus.c_datain, 0);
        chk({tag, "_dm"},   bus.c_dm, {MW{1'b1}});
    endtask

    // One complete arbitration round as the model sees it: grant, command,
    // data beats, completion (or timeout), then the two-cycle quiet gap.
    task automatic serve(input bit tmo_mode, input bit drop_early);
        int w, o, waited;
        bit seen;
        logic [DW-1:0] word;
        w = (req[0] && req[1]) ? exp_ptr : (req[1] ? 1 : 0);
        o = 1 - w;
        @(posedge clk); #1;
        exp_ptr = (w == 0) ? 1 : 0;
        chk("grant", gnt_of(w), 1);
        chk("other_gnt", gnt_of(o), 0);
        chk("c_addr", bus.c_addr, addr[w]);
        chk("c_length", bus.c_length, len[w]);
        chk("cmd_at_grant", {bus.c_wr, bus.c_rd}, 0);
        if (drop_early) begin req[w] = 1'b0; drive_ports(); end
        @(posedge clk); #1;
        if (len[w] == 8'd0) begin
            chk("zlen_done", done_of(w), 1);
            chk("zlen_gnt", {bus.p0_gnt, bus.p1_gnt}, 0);
            chk("zlen_cmd", {bus.c_wr, bus.c_rd}, 0);
            req[w] = 1'b0; drive_ports();
            return;
        end
        chk("cmd", {bus.c_wr, bus.c_rd}, wrn[w] ? 2'b10 : 2'b01);
        if (!tmo_mode) begin
            for (int i = 0; i < int'(len[w]); i++) begin
                word = DW'($urandom);
                if (wrn[w]) begin
                    din[w] = word; dm[w] = MW'($urandom); drive_ports();
                    bus.c_in_req = 1'b1;
                end else begin
                    bus.c_dataout = word; bus.c_out_valid = 1'b1;
                end
                #1;
                if (wrn[w]) begin
                    chk("in_req", inreq_of(w), 1);
                    chk("in_req_other", inreq_of(o), 0);
                    chk("c_datain", bus.c_datain, din[w]);
                    chk("c_dm", bus.c_dm, dm[w]);
                end else begin
                    chk("out_valid", ov_of(w), 1);
                    chk("out_valid_other", ov_of(o), 0);
                    chk("dout", dout_of(w), word);
                    chk("dout_other", dout_of(o), word);
                end
                @(posedge clk); #1;
                bus.c_in_req = 1'b0; bus.c_out_valid = 1'b0;
                chk("cmd_hold", {bus.c_wr, bus.c_rd}, wrn[w] ? 2'b10 : 2'b01);
            end
            bus.c_done = 1'b1;
            @(posedge clk); #1;
            bus.c_done = 1'b0;
            chk("done", done_of(w), 1);
            chk("err_on_done", {bus.p0_err, bus.p1_err}, 0);
        end else begin
            waited = 0; seen = 1'b0;
            while (!seen && waited < int'(TMO) + 8) begin
                @(posedge clk); #1;
                waited++;
                seen = err_of(w);
            end
            chk("tmo_latency", waited, TMO + 1);
            chk("err", err_of(w), 1);
            chk("done_on_err", {bus.p0_done, bus.p1_done}, 0);
        end
        chk("end_gnt", {bus.p0_gnt, bus.p1_gnt}, 0);
        chk("end_cmd", {bus.c_wr, bus.c_rd}, 0);
        chk("end_din_idle", bus.c_datain, 0);
        chk("end_dm_idle", bus.c_dm, {MW{1'b1}});
        req[w] = 1'b0; drive_ports();
        for (int g = 0; g < 2; g++) begin
            bus.c_done = (g == 0);   // stray completion outside WAIT
            @(posedge clk); #1;
            bus.c_done = 1'b0;
            chk("gap_gnt", {bus.p0_gnt, bus.p1_gnt}, 0);
            chk("gap_cmd", {bus.c_wr, bus.c_rd}, 0);
            chk("gap_pulses", {bus.p0_done, bus.p1_done, bus.p0_err, bus.p1_err}, 0);
        end
    endtask

    initial begin
        for (int p = 0; p < 2; p++) set_port(p, 1'b0, 1'b0, '0, 8'd0);
        drive_ports();
        bus.c_dataout = '0; bus.c_in_req = 1'b0; bus.c_out_valid = 1'b0;
        bus.c_done = 1'b0; bus.c_act = 1'b0;
        exp_ptr = 0;

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Simultaneous pair with pointer at P0: P0 then P1.
        set_port(0, 1'b1, 1'b1, AW'('h2A0), 8'd2);
        set_port(1, 1'b1, 1'b0, AW'('h3B0), 8'd3);
        drive_ports();
        serve(1'b0, 1'b0);
        serve(1'b0, 1'b0);

        // P0 write, 8 words at 0x100.
        set_port(0, 1'b1, 1'b1, AW'('h100), 8'd8);
        drive_ports();
        serve(1'b0, 1'b0);

        // Next simultaneous pair: pointer now favours P1.
        set_port(0, 1'b1, 1'b0, AW'('h040), 8'd1);
        set_port(1, 1'b1, 1'b1, AW'('h050), 8'd2);
        drive_ports();
        serve(1'b0, 1'b1);
        serve(1'b0, 1'b1);

        // P1 read, 4 words.
        set_port(1, 1'b1, 1'b0, AW'('h7FF), 8'd4);
        drive_ports();
        serve(1'b0, 1'b0);

        // Withheld completion on a P0 write: watchdog exit.
        set_port(0, 1'b1, 1'b1, AW'('h123), 8'd4);
        drive_ports();
        serve(1'b1, 1'b0);

        // Zero-length P1 request.
        set_port(1, 1'b1, 1'b1, AW'('h555), 8'd0);
        drive_ports();
        serve(1'b0, 1'b0);

        // Reset asserted while a burst is waiting on the controller.
        set_port(0, 1'b1, 1'b1, AW'('h0AA), 8'd5);
        drive_ports();
        @(posedge clk); #1;
        chk("rst_pre_gnt", bus.p0_gnt, 1);
        @(posedge clk); #1;
        chk("rst_pre_cmd", bus.c_wr, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midburst_reset");
        req[0] = 1'b0; drive_ports();
        exp_ptr = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b0, AW'('h0BB), 8'd3);
        drive_ports();
        serve(1'b0, 1'b0);

        // Randomized request mixes.
        for (int it = 0; it < 30; it++) begin
            for (int p = 0; p < 2; p++) begin
                set_port(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom),
                         ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 6)));
            end
            if (!req[0] && !req[1]) req[$urandom_range(0, 1)] = 1'b1;
            drive_ports();
            while (req[0] || req[1]) serve(1'b0, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
